// File: rtl/dma_region_guard.sv
// DMA access monitor: holds the core in reset after any access into a protected window.
// Optional violation log is built only when DMA_GUARD_LOG_EN is defined.
module dma_region_guard #(
  parameter int                        N_REGIONS      = 5,
  parameter logic [16*N_REGIONS-1:0]   REGION_BASE    = {16'h0130, 16'h0080, 16'hFFDF, 16'h9000, 16'hA000},
  parameter logic [16*N_REGIONS-1:0]   REGION_SIZE    = {16'h00D0, 16'h0010, 16'h0021, 16'h001F, 16'h1000},
  parameter logic [N_REGIONS-1:0]      REGION_WO_MASK = 5'b01110,
  parameter logic [15:0]               RESET_HANDLER  = 16'h0000,
  parameter logic [7:0]                HOLD_CYCLES    = 8'd4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] pc,
  input  logic [15:0] dma_addr,
  input  logic        dma_en,
  input  logic        dma_we,
  input  logic        log_clr,
  output logic        reset,
  output logic        viol_valid,
  output logic [3:0]  viol_region,
  output logic [15:0] viol_addr,
  output logic [7:0]  viol_count
);

  localparam logic [0:0] ST_KILL = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [N_REGIONS-1:0] viol_vec_s;
  logic                 violation_s;
  logic [3:0]           viol_idx_s;

  logic [0:0] state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic       reset_q, reset_d;

  // Window compare in 17 bits so a window ending at 0x10000 covers 0xFFFF.
  always_comb begin
    viol_vec_s = '0;
    for (int i = 0; i < N_REGIONS; i++) begin
      logic [16:0] lo_v, hi_v, a_v;
      lo_v = {1'b0, REGION_BASE[16*i +: 16]};
      hi_v = lo_v + {1'b0, REGION_SIZE[16*i +: 16]};
      a_v  = {1'b0, dma_addr};
      if (dma_en && (REGION_SIZE[16*i +: 16] != 16'h0000) && (a_v >= lo_v) && (a_v < hi_v)
          && (!REGION_WO_MASK[i] || dma_we)) begin
        viol_vec_s[i] = 1'b1;
      end else begin
        viol_vec_s[i] = 1'b0;
      end
    end
  end

  assign violation_s = |viol_vec_s;

  // Lowest violating region index wins when windows overlap.
  always_comb begin
    viol_idx_s = 4'd0;
    for (int i = N_REGIONS - 1; i >= 0; i--) begin
      if (viol_vec_s[i]) begin
        viol_idx_s = 4'(i);
      end else begin
        viol_idx_s = viol_idx_s;
      end
    end
  end

  // Kill/run sequencing with reloadable hold counter.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      ST_KILL: begin
        if (violation_s) begin
          hold_d = HOLD_CYCLES;
        end else if ((hold_q == 8'd0) && (pc == RESET_HANDLER)) begin
          state_d = ST_RUN;
        end else if (hold_q != 8'd0) begin
          hold_d = hold_q - 8'd1;
        end else begin
          hold_d = hold_q;
        end
      end
      ST_RUN: begin
        if (violation_s) begin
          state_d = ST_KILL;
          hold_d  = HOLD_CYCLES;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_KILL;
        hold_d  = HOLD_CYCLES;
      end
    endcase
    reset_d = (state_d == ST_KILL);
  end

  // State, hold counter and registered reset request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_KILL;
      hold_q  <= HOLD_CYCLES;
      reset_q <= 1'b1;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      reset_q <= reset_d;
    end
  end

  assign reset = reset_q;

`ifdef DMA_GUARD_LOG_EN
  logic        valid_q, valid_d;
  logic [3:0]  region_q, region_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  count_q, count_d;

  // First violation is captured; a same-cycle clear loses to a violation.
  always_comb begin
    valid_d  = valid_q;
    region_d = region_q;
    addr_d   = addr_q;
    count_d  = count_q;
    if (violation_s) begin
      if (!valid_q || log_clr) begin
        valid_d  = 1'b1;
        region_d = viol_idx_s;
        addr_d   = dma_addr;
      end else begin
        valid_d  = valid_q;
      end
      if (log_clr) begin
        count_d = 8'd1;
      end else if (count_q != 8'hFF) begin
        count_d = count_q + 8'd1;
      end else begin
        count_d = count_q;
      end
    end else if (log_clr) begin
      valid_d  = 1'b0;
      region_d = 4'd0;
      addr_d   = 16'h0000;
      count_d  = 8'd0;
    end else begin
      valid_d  = valid_q;
    end
  end

  // Violation log registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q  <= 1'b0;
      region_q <= 4'd0;
      addr_q   <= 16'h0000;
      count_q  <= 8'd0;
    end else begin
      valid_q  <= valid_d;
      region_q <= region_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
    end
  end

  assign viol_valid  = valid_q;
  assign viol_region = region_q;
  assign viol_addr   = addr_q;
  assign viol_count  = count_q;
`else
  logic unused_log_s;
  assign unused_log_s = log_clr ^ (|viol_idx_s);
  assign viol_valid  = 1'b0;
  assign viol_region = 4'd0;
  assign viol_addr   = 16'h0000;
  assign viol_count  = 8'd0;
`endif

endmodule

// File: tb/tb_dma_region_guard.sv
// Directed-vector bench for dma_region_guard; log expectations follow DMA_GUARD_LOG_EN.
module tb_dma_region_guard;

`ifdef DMA_GUARD_LOG_EN
  localparam bit LOG_EN = 1'b1;
`else
  localparam bit LOG_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] pc;
  logic [15:0] dma_addr;
  logic        dma_en;
  logic        dma_we;
  logic        log_clr;
  logic        reset;
  logic        viol_valid;
  logic [3:0]  viol_region;
  logic [15:0] viol_addr;
  logic [7:0]  viol_count;
  logic        z_reset;
  logic        z_valid;
  logic [3:0]  z_region;
  logic [15:0] z_addr;
  logic [7:0]  z_count;

  int n_vec  = 0;
  int n_miss = 0;
  int exp_cnt;

  always #5 clk = ~clk;

  dma_region_guard u_dut (
    .clk(clk), .reset_n(reset_n), .pc(pc), .dma_addr(dma_addr), .dma_en(dma_en),
    .dma_we(dma_we), .log_clr(log_clr), .reset(reset), .viol_valid(viol_valid),
    .viol_region(viol_region), .viol_addr(viol_addr), .viol_count(viol_count)
  );

  // Single zero-size window: must never hit.
  dma_region_guard #(
    .N_REGIONS(1), .REGION_BASE(16'hFFF0), .REGION_SIZE(16'h0000), .REGION_WO_MASK(1'b0)
  ) u_zero (
    .clk(clk), .reset_n(reset_n), .pc(pc), .dma_addr(dma_addr), .dma_en(dma_en),
    .dma_we(dma_we), .log_clr(log_clr), .reset(z_reset), .viol_valid(z_valid),
    .viol_region(z_region), .viol_addr(z_addr), .viol_count(z_count)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lg(input logic [31:0] v);
    return LOG_EN ? v : 32'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_log(input string tag, input logic v, input logic [3:0] r,
                           input logic [15:0] a, input logic [7:0] c);
    chk_eq({tag, "_valid"},  {31'd0, viol_valid}, lg({31'd0, v}));
    chk_eq({tag, "_region"}, {28'd0, viol_region}, lg({28'd0, r}));
    chk_eq({tag, "_addr"},   {16'd0, viol_addr},   lg({16'd0, a}));
    chk_eq({tag, "_count"},  {24'd0, viol_count},  lg({24'd0, c}));
  endtask

  task automatic release_wait(input string tag, input int exp_ticks);
    int n;
    n = 0;
    while (reset && n < 50) begin
      tick();
      n++;
    end
    chk_eq(tag, n, exp_ticks);
  endtask

  task automatic access(input logic [15:0] a, input logic we, input logic clr);
    dma_en = 1'b1; dma_addr = a; dma_we = we; log_clr = clr;
    tick();
    dma_en = 1'b0; dma_we = 1'b0; log_clr = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; pc = 16'h0000; dma_addr = 16'h0000;
    dma_en = 1'b0; dma_we = 1'b0; log_clr = 1'b0;
    #22;
    chk_eq("rst_reset", {31'd0, reset}, 32'd1);
    check_log("rst", 1'b0, 4'd0, 16'h0000, 8'd0);
    reset_n = 1'b1;

    // Release takes HOLD_CYCLES+1 = 5 edges.
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk_eq($sformatf("hold_edge%0d", k), {31'd0, reset}, 32'd1);
    end
    tick();
    chk_eq("release_edge5", {31'd0, reset}, 32'd0);
    chk_eq("zero_released", {31'd0, z_reset}, 32'd0);

    // Region 0, any access.
    access(16'hA000, 1'b0, 1'b0);
    chk_eq("r0_reset", {31'd0, reset}, 32'd1);
    check_log("r0", 1'b1, 4'd0, 16'hA000, 8'd1);
    release_wait("r0_release", 5);
    access(16'hB000, 1'b0, 1'b0);
    chk_eq("b000_none", {31'd0, reset}, 32'd0);

    log_clr = 1'b1; tick(); log_clr = 1'b0;
    check_log("clr1", 1'b0, 4'd0, 16'h0000, 8'd0);

    // Region 1 is write-only.
    access(16'h9010, 1'b0, 1'b0);
    chk_eq("9010_read", {31'd0, reset}, 32'd0);
    access(16'h9010, 1'b1, 1'b0);
    chk_eq("9010_write", {31'd0, reset}, 32'd1);
    check_log("r1", 1'b1, 4'd1, 16'h9010, 8'd1);
    release_wait("r1_release", 5);

    // Top boundary.
    access(16'hFFDE, 1'b1, 1'b0);
    chk_eq("ffde_none", {31'd0, reset}, 32'd0);
    log_clr = 1'b1; tick(); log_clr = 1'b0;
    access(16'hFFFF, 1'b1, 1'b0);
    chk_eq("ffff_reset", {31'd0, reset}, 32'd1);
    check_log("r2", 1'b1, 4'd2, 16'hFFFF, 8'd1);
    chk_eq("zero_nohit", {31'd0, z_reset}, 32'd0);
    release_wait("r2_release", 5);

    // Clear and violation in the same cycle: violation wins.
    access(16'h0085, 1'b1, 1'b1);
    chk_eq("race_reset", {31'd0, reset}, 32'd1);
    check_log("race", 1'b1, 4'd3, 16'h0085, 8'd1);
    exp_cnt = 1;

    // Violations every other cycle keep the core in reset.
    for (int k = 0; k < 10; k++) begin
      access(16'hA123, 1'b0, 1'b0);
      exp_cnt++;
      tick();
      if (reset !== 1'b1) chk_eq("held_kill", {31'd0, reset}, 32'd1);
    end
    chk_eq("held_kill_end", {31'd0, reset}, 32'd1);
    chk_eq("held_count", {24'd0, viol_count}, lg(exp_cnt));

    // Continuous violations saturate the counter.
    dma_en = 1'b1; dma_addr = 16'h0150; dma_we = 1'b0;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (exp_cnt < 255) exp_cnt++;
    end
    dma_en = 1'b0;
    check_log("sat", 1'b1, 4'd3, 16'h0085, 8'(exp_cnt));
    chk_eq("sat_exp255", exp_cnt, 32'd255);
    release_wait("sat_release", 5);

    // Asynchronous reset mid-operation.
    access(16'h0140, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_eq("async_reset", {31'd0, reset}, 32'd1);
    check_log("async", 1'b0, 4'd0, 16'h0000, 8'd0);
    #10;
    reset_n = 1'b1;
    release_wait("async_release", 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/dma_region_guard.md
# dma_region_guard

Parametrised DMA access monitor: the next generation of the fixed five-region DMA guard. Compares every DMA bus access against `N_REGIONS` configurable protected address windows, each with its own access mode. Holds the core in reset on any violation until a minimum kill period has elapsed and the CPU is back at the reset handler. Sits beside the openMSP430 core on the DMA address bus and feeds the system reset OR-tree.

## Interface
- `N_REGIONS`, 5: number of protected windows (1..16).
- `REGION_BASE`, {16'h0130,16'h0080,16'hFFDF,16'h9000,16'hA000}: packed `16*N_REGIONS` bases; region i occupies bits `[16*i+15:16*i]`.
- `REGION_SIZE`, {16'h00D0,16'h0010,16'h0021,16'h001F,16'h1000}: packed `16*N_REGIONS` sizes; size 0 disables the region.
- `REGION_WO_MASK`, 5'b01110: bit i = 1 means only DMA writes into region i violate; bit i = 0 means any access violates.
- `RESET_HANDLER`, 16'h0000: PC value that permits leaving KILL.
- `HOLD_CYCLES`, 8'd4: minimum number of cycles spent in KILL before release (0 allowed).
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `pc`  in  16  current CPU program counter.
- `dma_addr`  in  16  DMA address.
- `dma_en`  in  1  DMA access strobe.
- `dma_we`  in  1  DMA write qualifier; valid when `dma_en`=1.
- `log_clr`  in  1  clears the violation log (single-cycle pulse).
- `reset`  out  1  registered reset request to the core.
- `viol_valid`  out  1  sticky: log holds a captured violation.
- `viol_region`  out  4  index of the captured violating region.
- `viol_addr`  out  16  captured violating DMA address.
- `viol_count`  out  8  saturating count of violation cycles.

## Operation
- Per-region hit: `dma_en && base <= dma_addr < base+size`, computed in 17-bit arithmetic (0xFFDF+0x21 = 0x10000 must cover 0xFFFF with no wrap); size 0 never hits.
- Region violation: hit && (`!WO_MASK[i]` || `dma_we`). `violation` = OR over regions. Lowest index wins for logging when windows overlap.
- States: KILL, RUN. 8-bit hold counter `hold_cnt`.
- On asynchronous reset: state=KILL, `hold_cnt`=HOLD_CYCLES, `reset`=1, log cleared (`viol_valid`=0, region/addr/count=0).
- KILL: `hold_cnt` decrements to 0 and stops there. Transition to RUN when `hold_cnt`==0 && `pc`==RESET_HANDLER && !violation. Otherwise stay; a violation while in KILL reloads `hold_cnt`=HOLD_CYCLES.
- RUN: on violation, go to KILL and load `hold_cnt`=HOLD_CYCLES; otherwise stay.
- `reset` = 1 in KILL, 0 in RUN, updated on the same edge as the state.
- Log (macro-gated, see Configuration):
  - On the first violation cycle while `viol_valid`=0, capture region and address and set `viol_valid`. Later violations do not overwrite.
  - `viol_count` increments on every violation cycle, in either state, and saturates at 255.
  - `log_clr` clears valid/region/addr/count. If `log_clr` and a violation occur in the same cycle, the violation wins: capture the new one and set count to 1.

## Timing
- Violation at edge N: `reset`=1 after edge N. Single-cycle latency; no combinational path from inputs to `reset`.
- Minimum KILL duration after a violation: HOLD_CYCLES+1 cycles, provided `pc` is already RESET_HANDLER. HOLD_CYCLES=0 gives the legacy one-cycle behaviour.
- Release: `reset`=0 after the first edge where the KILL exit condition holds.
- Log outputs update on the same edge as the violation.
- `reset_n` assertion mid-operation forces KILL and clears the log immediately (asynchronous). Release is synchronous to `clk`.

## Configuration
- `DMA_GUARD_LOG_EN` defined: violation log registers and `log_clr` are implemented as described.
- Undefined: no log flops. `viol_valid`, `viol_region`, `viol_addr` and `viol_count` are tied to 0, and `log_clr` is ignored. Reset/state behaviour is identical.

## Test plan
- Reset release: `reset_n` 0→1 with `pc`=0x0000 and no DMA -> `reset` stays 1 for 5 edges (HOLD_CYCLES=4), then falls to 0.
- RUN violation: in RUN, `dma_en`=1, `dma_addr`=0xA000, `dma_we`=0 -> next edge `reset`=1, `viol_region`=0, `viol_addr`=0xA000, `viol_count`=1. Address 0xB000 -> no violation.
- Write-only mode: `dma_addr`=0x9010 read -> no violation; same address with `dma_we`=1 -> violation, `viol_region`=1.
- Top boundary: `dma_addr`=0xFFFF write -> violation, region 2. `dma_addr`=0xFFDE -> none. A region with size 0 never hits.
- Held kill: repeated violations every 2 cycles while `pc`=0 -> `reset` stays 1 throughout and `hold_cnt` reloads. `viol_count` increments to 255 and holds there.
- Log clear race: `log_clr`=1 in the same cycle as a violation at 0x0085 -> `viol_valid`=1, `viol_addr`=0x0085, `viol_count`=1. With `DMA_GUARD_LOG_EN` undefined, all log outputs stay 0.
